te_frame_sync: RTL and testbench

TE_FRAME_SYNC -- requirements
Module: te_frame_sync

---
 rtl/te_frame_sync.sv | 159 +++++++++++++++
 tb/tb_te_frame_sync.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/te_frame_sync.sv
// Frame/line sequencer triggered by the display tearing-effect (TE) pulse.
// Hands out line requests with fixed idle gaps and tracks missed or absent TE edges.
module te_frame_sync #(
    parameter int unsigned V_LINES    = 1080,
    parameter int unsigned LINE_GAP   = 16,
    parameter int unsigned TE_TIMEOUT = 1500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        te,
    input  logic        clr_status,
    input  logic        line_done,
    output logic        line_req,
    output logic [10:0] line_num,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy,
    output logic        te_missed,
    output logic        te_timeout,
    output logic [7:0]  overrun_cnt
);

    localparam logic [10:0] LAST_LINE = 11'(V_LINES - 1);
    localparam logic [7:0]  GAP_LAST  = 8'(LINE_GAP - 1);
    localparam logic [23:0] TO_LIMIT  = 24'(TE_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        LINE,
        GAP
    } state_t;

    state_t      state_q, state_d;
    logic        te_s1_q, te_s1_d;
    logic        te_s2_q, te_s2_d;
    logic        te_dly_q, te_dly_d;
    logic [10:0] line_num_q, line_num_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_done_q, frame_done_d;
    logic        te_missed_q, te_missed_d;
    logic        te_timeout_q, te_timeout_d;
    logic [7:0]  overrun_q, overrun_d;
    logic [23:0] to_cnt_q, to_cnt_d;
    logic        rise;
    logic        missed;

    always_comb begin
        te_s1_d       = te;
        te_s2_d       = te_s1_q;
        te_dly_d      = te_s2_q;
        rise          = te_s2_q & ~te_dly_q;
        state_d       = state_q;
        line_num_d    = line_num_q;
        gap_cnt_d     = gap_cnt_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;

        // The frame_done cycle is still treated as part of the frame, so a
        // rise there is a miss and can never start the next frame.
        missed = rise & ((state_q != IDLE) | frame_done_q);

        case (state_q)
            IDLE: begin
                if (rise && en && !frame_done_q) begin
                    state_d       = LINE;
                    line_num_d    = '0;
                    frame_start_d = 1'b1;
                end
            end
            LINE: begin
                if (line_done) begin
                    if (line_num_q == LAST_LINE) begin
                        state_d      = IDLE;
                        line_num_d   = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d    = LINE;
                    line_num_d = line_num_q + 11'd1;
                    gap_cnt_d  = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear first, then let a coincident event override it.
        te_missed_d  = clr_status ? 1'b0 : te_missed_q;
        overrun_d    = clr_status ? 8'd0 : overrun_q;
        te_timeout_d = clr_status ? 1'b0 : te_timeout_q;

        if (missed) begin
            te_missed_d = 1'b1;
            if (overrun_d != 8'hFF) begin
                overrun_d = overrun_d + 8'd1;
            end
        end

        if (rise) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LIMIT) begin
            to_cnt_d = to_cnt_q;
        end else begin
            to_cnt_d = to_cnt_q + 24'd1;
            if (to_cnt_d == TO_LIMIT) begin
                te_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            te_s1_q       <= 1'b0;
            te_s2_q       <= 1'b0;
            te_dly_q      <= 1'b0;
            line_num_q    <= '0;
            gap_cnt_q     <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            te_missed_q   <= 1'b0;
            te_timeout_q  <= 1'b0;
            overrun_q     <= '0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            te_s1_q       <= te_s1_d;
            te_s2_q       <= te_s2_d;
            te_dly_q      <= te_dly_d;
            line_num_q    <= line_num_d;
            gap_cnt_q     <= gap_cnt_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            te_missed_q   <= te_missed_d;
            te_timeout_q  <= te_timeout_d;
            overrun_q     <= overrun_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    assign line_req    = (state_q == LINE);
    assign busy        = (state_q != IDLE);
    assign line_num    = line_num_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign te_missed   = te_missed_q;
    assign te_timeout  = te_timeout_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_te_frame_sync.sv
// Bench for te_frame_sync with a 4-line frame, 2-cycle line gap and 50-cycle TE timeout.
module tb_te_frame_sync;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        te = 1'b0;
    logic        clr_status = 1'b0;
    logic        line_done = 1'b0;
    logic        line_req;
    logic [10:0] line_num;
    logic        frame_start;
    logic        frame_done;
    logic        busy;
    logic        te_missed;
    logic        te_timeout;
    logic [7:0]  overrun_cnt;

    int total = 0;
    int bad = 0;
    int fs_cnt = 0;
    int fd_cnt = 0;

    te_frame_sync #(
        .V_LINES   (4),
        .LINE_GAP  (2),
        .TE_TIMEOUT(50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .te         (te),
        .clr_status (clr_status),
        .line_done  (line_done),
        .line_req   (line_req),
        .line_num   (line_num),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .busy       (busy),
        .te_missed  (te_missed),
        .te_timeout (te_timeout),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_start === 1'b1) fs_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
    end

    typedef struct {
        logic        rst, en, te, clr, ld;
        logic        req;
        logic [10:0] num;
        logic        fs, fd, busy, missed, tmo;
        logic [7:0]  ovr;
    } vec_t;

    vec_t tbl[20];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_req(input int exp_wait);
        int n = 0;
        while (line_req !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("line_req_wait", n, exp_wait);
    endtask

    // mode: 0 plain, 1 extra TE early in the line, 2 TE timed to rise in the
    // frame_done cycle, 3 drop en during the line
    task automatic do_line(input int l, input int exp_wait, input int mode);
        wait_req(exp_wait);
        chk("line_num", line_num, l);
        for (int i = 0; i < 4; i++) begin
            if (mode == 1 && i == 0) te = 1'b1;
            if (mode == 2 && i == 3) te = 1'b1;
            if (mode == 3 && i == 0) en = 1'b0;
            step();
            te = 1'b0;
            chk("line_req_hold", line_req, 1);
            chk("line_num_hold", line_num, l);
        end
        line_done = 1'b1;
        step();
        line_done = 1'b0;
        chk("line_req_drop", line_req, 0);
    endtask

    task automatic start_frame();
        te = 1'b1;
        step();
        te = 1'b0;
        wait_req(2);
        chk("frame_start", frame_start, 1);
        chk("start_line_num", line_num, 0);
        chk("start_busy", busy, 1);
    endtask

    task automatic check_end();
        chk("frame_done", frame_done, 1);
        chk("end_busy", busy, 0);
        chk("end_line_num", line_num, 0);
        step();
        chk("frame_done_pulse", frame_done, 0);
    endtask

    task automatic frame(input int mode_line, input int mode);
        start_frame();
        for (int l = 0; l < 4; l++)
            do_line(l, (l == 0) ? 0 : 2, (l == mode_line) ? mode : 0);
        check_end();
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
    endtask

    initial begin
        int fs0;
        int fd0;

        //              rst en te clr ld  req num fs fd busy mis tmo ovr
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

        #2;
        for (int i = 0; i < 20; i++) begin
            rst = tbl[i].rst;
            en = tbl[i].en;
            te = tbl[i].te;
            clr_status = tbl[i].clr;
            line_done = tbl[i].ld;
            step();
            chk($sformatf("v%0d_line_req", i), line_req, tbl[i].req);
            chk($sformatf("v%0d_line_num", i), line_num, tbl[i].num);
            chk($sformatf("v%0d_frame_start", i), frame_start, tbl[i].fs);
            chk($sformatf("v%0d_frame_done", i), frame_done, tbl[i].fd);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("v%0d_te_missed", i), te_missed, tbl[i].missed);
            chk($sformatf("v%0d_te_timeout", i), te_timeout, tbl[i].tmo);
            chk($sformatf("v%0d_overrun", i), overrun_cnt, tbl[i].ovr);
        end
        line_done = 1'b0;
        en = 1'b1;

        // Plain frame
        fs0 = fs_cnt; fd0 = fd_cnt;
        frame(0, 0);
        chk("plain_fs_count", fs_cnt - fs0, 1);
        chk("plain_fd_count", fd_cnt - fd0, 1);
        chk("plain_missed", te_missed, 0);

        // Extra TE mid-frame
        fs0 = fs_cnt;
        frame(1, 1);
        chk("extra_fs_count", fs_cnt - fs0, 1);
        chk("extra_missed", te_missed, 1);
        chk("extra_overrun", overrun_cnt, 1);

        // 300 more misses saturate the counter
        fs0 = fs_cnt;
        start_frame();
        for (int i = 0; i < 300; i++) begin
            te = 1'b1; step();
            te = 1'b0; step();
        end
        step(); step();
        chk("sat_overrun", overrun_cnt, 255);
        chk("sat_line_num", line_num, 0);
        chk("sat_line_req", line_req, 1);
        for (int l = 0; l < 4; l++) do_line(l, (l == 0) ? 0 : 2, 0);
        check_end();
        chk("sat_fs_count", fs_cnt - fs0, 1);

        pulse_clr();
        chk("clr_missed", te_missed, 0);
        chk("clr_overrun", overrun_cnt, 0);

        // Rise landing in the frame_done cycle
        fs0 = fs_cnt;
        frame(3, 2);
        chk("fd_rise_missed", te_missed, 1);
        chk("fd_rise_overrun", overrun_cnt, 1);
        repeat (4) step();
        chk("fd_rise_busy", busy, 0);
        chk("fd_rise_fs_count", fs_cnt - fs0, 1);

        // en dropped mid-frame
        fs0 = fs_cnt; fd0 = fd_cnt;
        frame(1, 3);
        chk("dropen_fd_count", fd_cnt - fd0, 1);
        te = 1'b1; step(); te = 1'b0;
        repeat (5) step();
        chk("dropen_fs_count", fs_cnt - fs0, 1);
        chk("dropen_busy", busy, 0);
        en = 1'b1;

        // clr_status coincident with a miss
        pulse_clr();
        start_frame();
        for (int i = 0; i < 2; i++) begin
            te = 1'b1; step(); te = 1'b0;
            repeat (3) step();
        end
        chk("pre_clr_overrun", overrun_cnt, 2);
        te = 1'b1; step(); te = 1'b0;
        step();
        clr_status = 1'b1; step(); clr_status = 1'b0;
        chk("clr_vs_rise_overrun", overrun_cnt, 1);
        chk("clr_vs_rise_missed", te_missed, 1);
        for (int l = 0; l < 4; l++) do_line(l, (l == 0) ? 0 : 2, 0);
        check_end();

        // Reset in GAP with line_num 2
        start_frame();
        for (int l = 0; l < 3; l++) do_line(l, (l == 0) ? 0 : 2, 0);
        chk("gap_line_num", line_num, 2);
        chk("gap_busy", busy, 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_line_req", line_req, 0);
        chk("rst_line_num", line_num, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_missed", te_missed, 0);
        chk("rst_timeout", te_timeout, 0);
        chk("rst_overrun", overrun_cnt, 0);
        frame(-1, 0);

        // TE held high through reset release still produces a rise
        te = 1'b1;
        rst = 1'b1; step(); rst = 1'b0;
        wait_req(3);
        chk("held_te_frame_start", frame_start, 1);
        te = 1'b0;
        for (int l = 0; l < 4; l++) do_line(l, (l == 0) ? 0 : 2, 0);
        check_end();

        // Timeout
        en = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        repeat (49) step();
        chk("timeout_before", te_timeout, 0);
        step();
        chk("timeout_at", te_timeout, 1);
        te = 1'b1; step(); te = 1'b0;
        repeat (3) step();
        chk("timeout_sticky", te_timeout, 1);
        pulse_clr();
        chk("timeout_cleared", te_timeout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
